// File: rtl/pipearch_dma_pkg.sv
// Shared DMA types for the pipearch read path: line/address/mdata types and reader FSM states.
// Pure declarations, so there is no latency or backpressure here.
package pipearch_dma_pkg;

  localparam int LINE_BITS      = 512;
  localparam int LINE_BYTES     = LINE_BITS / 8;
  localparam int DEF_ADDR_BITS  = 42;
  localparam int DEF_MDATA_BITS = 16;

  typedef logic [LINE_BITS-1:0]      t_line;
  typedef logic [DEF_ADDR_BITS-1:0]  t_line_addr;
  typedef logic [DEF_MDATA_BITS-1:0] t_mdata;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_DRAIN,
    RD_DONE
  } t_rd_state;

  // CCI-P addresses whole cache lines; software-side buffers are byte addressed.
  function automatic logic [DEF_ADDR_BITS+5:0] line_to_byte_addr(input t_line_addr a);
    return {a, 6'b0} & {(DEF_ADDR_BITS+6){LINE_BYTES == 64}};
  endfunction

endpackage

// File: rtl/ccip_line_reader_if.sv
// Control, CCI-P channel-0 and output-stream signals of the line reader.
// master = the reader itself, slave = the wrapper/consumer side.
interface ccip_line_reader_if
  import pipearch_dma_pkg::*;
#(
  parameter int ADDR_BITS  = 42,
  parameter int LEN_BITS   = 32,
  parameter int MDATA_BITS = 16
);

  logic                  start;
  logic [ADDR_BITS-1:0]  start_addr;
  logic [LEN_BITS-1:0]   num_lines;
  logic                  busy;
  logic                  done;

  logic                  c0_tx_valid;
  logic [ADDR_BITS-1:0]  c0_tx_addr;
  logic [MDATA_BITS-1:0] c0_tx_mdata;
  logic                  c0_tx_alm_full;

  logic                  c0_rx_rd_valid;
  logic [MDATA_BITS-1:0] c0_rx_mdata;
  t_line                 c0_rx_data;

  logic                  out_valid;
  t_line                 out_data;
  logic [MDATA_BITS-1:0] out_idx;
  logic                  out_ready;

  modport master (
    input  start, start_addr, num_lines,
    output busy, done,
    output c0_tx_valid, c0_tx_addr, c0_tx_mdata,
    input  c0_tx_alm_full,
    input  c0_rx_rd_valid, c0_rx_mdata, c0_rx_data,
    output out_valid, out_data, out_idx,
    input  out_ready
  );

  modport slave (
    output start, start_addr, num_lines,
    input  busy, done,
    input  c0_tx_valid, c0_tx_addr, c0_tx_mdata,
    output c0_tx_alm_full,
    output c0_rx_rd_valid, c0_rx_mdata, c0_rx_data,
    input  out_valid, out_data, out_idx,
    output out_ready
  );

endinterface

// File: rtl/ccip_line_fifo.sv
// Power-of-2 FIFO with a registered read port (head word visible one cycle after push).
// No backpressure on push; the producer must respect full. Pop is ignored when empty.
module ccip_line_fifo
  import pipearch_dma_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [WIDTH-1:0]    rd_dat_q;
  logic                wr_en, rd_en;

  assign full_o  = (count_q == CNT_BITS'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rd_dat_o = rd_dat_q;

  assign wr_en    = push_i && (!full_o || pop_i);
  assign rd_en    = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + PTR_BITS'(wr_en);
  assign rd_ptr_d = rd_ptr_q + PTR_BITS'(rd_en);
  assign count_d  = count_q + CNT_BITS'(wr_en) - CNT_BITS'(rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= push_dat_i;
    end
  end

  // Output register tracks the next head; bypass when that slot is written this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_dat_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
        rd_dat_q <= push_dat_i;
      end else begin
        rd_dat_q <= mem[rd_ptr_d];
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push_i |-> (!full_o || pop_i));

endmodule

// File: rtl/ccip_line_reader.sv
// CCI-P channel-0 DMA reader: streams num_lines lines from start_addr, tagged with line offset.
// Requests appear one cycle after firing; alm_full and the credit limit stall issue; out_ready stalls the stream.
module ccip_line_reader
  import pipearch_dma_pkg::*;
#(
  parameter int ADDR_BITS       = 42,
  parameter int LEN_BITS        = 32,
  parameter int MAX_OUTSTANDING = 64,
  parameter int MDATA_BITS      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  ccip_line_reader_if.master  rd
);

  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING) + 1;
  localparam int FIFO_W   = MDATA_BITS + LINE_BITS;

  t_rd_state             state_q;
  logic                  busy_q, done_q, tx_valid_q;
  logic [ADDR_BITS-1:0]  start_addr_q, tx_addr_q;
  logic [MDATA_BITS-1:0] tx_mdata_q;
  logic [LEN_BITS-1:0]   num_lines_q;
  logic [LEN_BITS-1:0]   req_cnt_q, req_cnt_d;
  logic [LEN_BITS-1:0]   pop_cnt_q, pop_cnt_d;
  logic [CNT_BITS-1:0]   in_flight_q, in_flight_d;

  logic                  fire, pop, pop_credit, active;
  logic                  fifo_full, fifo_empty;
  logic [CNT_BITS-1:0]   fifo_cnt;
  logic [FIFO_W-1:0]     fifo_rd_dat;

  assign active = (state_q == RD_ISSUE) || (state_q == RD_DRAIN);

  assign fire = (state_q == RD_ISSUE) && !rd.c0_tx_alm_full
             && (in_flight_q < CNT_BITS'(MAX_OUTSTANDING))
             && (req_cnt_q < num_lines_q);

  assign pop = !fifo_empty && rd.out_ready;

  // Stray pops (responses surviving a reset) must not underflow the credit counter.
  assign pop_credit  = pop && (in_flight_q != '0);
  assign in_flight_d = in_flight_q + CNT_BITS'(fire) - CNT_BITS'(pop_credit);
  assign req_cnt_d   = req_cnt_q + LEN_BITS'(fire);
  assign pop_cnt_d   = pop_cnt_q + LEN_BITS'(pop && active);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RD_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_addr_q    <= '0;
      tx_mdata_q   <= '0;
      start_addr_q <= '0;
      num_lines_q  <= '0;
      req_cnt_q    <= '0;
      pop_cnt_q    <= '0;
      in_flight_q  <= '0;
    end else begin
      tx_valid_q  <= fire;
      done_q      <= 1'b0;
      in_flight_q <= in_flight_d;
      pop_cnt_q   <= pop_cnt_d;
      if (fire) begin
        tx_addr_q  <= start_addr_q + ADDR_BITS'(req_cnt_q);
        tx_mdata_q <= req_cnt_q[MDATA_BITS-1:0];
        req_cnt_q  <= req_cnt_d;
      end

      case (state_q)
        RD_IDLE: begin
          if (rd.start) begin
            start_addr_q <= rd.start_addr;
            num_lines_q  <= rd.num_lines;
            req_cnt_q    <= '0;
            pop_cnt_q    <= '0;
            in_flight_q  <= '0;
            busy_q       <= 1'b1;
            if (rd.num_lines == '0) begin
              state_q <= RD_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          if (fire && (req_cnt_d == num_lines_q)) begin
            state_q <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (pop_cnt_d == num_lines_q) begin
            state_q <= RD_DONE;
            done_q  <= 1'b1;
          end
        end
        RD_DONE: begin
          busy_q  <= 1'b0;
          state_q <= RD_IDLE;
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  ccip_line_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .push_i     (rd.c0_rx_rd_valid),
    .push_dat_i ({rd.c0_rx_mdata, rd.c0_rx_data}),
    .pop_i      (pop),
    .rd_dat_o   (fifo_rd_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  assign rd.busy        = busy_q;
  assign rd.done        = done_q;
  assign rd.c0_tx_valid = tx_valid_q;
  assign rd.c0_tx_addr  = tx_addr_q;
  assign rd.c0_tx_mdata = tx_mdata_q;
  assign rd.out_valid   = !fifo_empty;
  assign rd.out_data    = fifo_rd_dat[LINE_BITS-1:0];
  assign rd.out_idx     = fifo_rd_dat[FIFO_W-1:LINE_BITS];

  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!reset_n)
    rd.c0_rx_rd_valid |-> (state_q != RD_IDLE));

  a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
    in_flight_q <= CNT_BITS'(MAX_OUTSTANDING));

  a_fifo_count: assert property (@(posedge clk) disable iff (!reset_n)
    fifo_full |-> (fifo_cnt == CNT_BITS'(MAX_OUTSTANDING)));

endmodule

// File: tb/tb_ccip_line_reader.sv
// Directed bench for ccip_line_reader with a 10-cycle in-order host model and a manual response path.
module tb_ccip_line_reader;
  import pipearch_dma_pkg::*;

  localparam int AB   = 42;
  localparam int LB   = 32;
  localparam int MB   = 16;
  localparam int MAXO = 4;

  typedef struct {
    logic [AB-1:0] addr;
    int            due;
  } req_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ccip_line_reader_if #(.ADDR_BITS(AB), .LEN_BITS(LB), .MDATA_BITS(MB)) rd_if ();

  ccip_line_reader #(
    .ADDR_BITS       (AB),
    .LEN_BITS        (LB),
    .MAX_OUTSTANDING (MAXO),
    .MDATA_BITS      (MB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rd      (rd_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int busy_cyc = 0;

  req_t          pend[$];
  logic [AB-1:0] req_addr_log[$];
  logic [MB-1:0] req_md_log[$];
  logic [MB-1:0] pop_idx_log[$];
  t_line         pop_dat_log[$];

  bit            auto_resp = 1'b1;
  bit            man_vld   = 1'b0;
  logic [MB-1:0] man_md    = '0;
  t_line         man_dat   = '0;

  function automatic t_line line_of(input logic [AB-1:0] a);
    return {16{a[31:0] ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [AB-1:0] get_addr(input int i);
    return (i < req_addr_log.size()) ? req_addr_log[i] : 'x;
  endfunction
  function automatic logic [MB-1:0] get_md(input int i);
    return (i < req_md_log.size()) ? req_md_log[i] : 'x;
  endfunction
  function automatic logic [MB-1:0] get_idx(input int i);
    return (i < pop_idx_log.size()) ? pop_idx_log[i] : 'x;
  endfunction
  function automatic t_line get_dat(input int i);
    return (i < pop_dat_log.size()) ? pop_dat_log[i] : 'x;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Host model: logs every request and answers it 10 cycles later unless in manual mode.
  initial begin
    req_t r;
    rd_if.c0_rx_rd_valid = 1'b0;
    rd_if.c0_rx_mdata    = '0;
    rd_if.c0_rx_data     = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend.delete();
        rd_if.c0_rx_rd_valid = 1'b0;
      end else begin
        if (rd_if.c0_tx_valid) begin
          pend.push_back('{rd_if.c0_tx_addr, cyc + 10});
          req_addr_log.push_back(rd_if.c0_tx_addr);
          req_md_log.push_back(rd_if.c0_tx_mdata);
        end
        if (auto_resp) begin
          if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            rd_if.c0_rx_rd_valid = 1'b1;
            rd_if.c0_rx_mdata    = MB'(r.addr - (r.addr & ~AB'(16'hFFFF)));
            rd_if.c0_rx_mdata    = req_md_log[req_md_log.size() - 1 - pend.size()];
            rd_if.c0_rx_data     = line_of(r.addr);
          end else begin
            rd_if.c0_rx_rd_valid = 1'b0;
          end
        end else begin
          rd_if.c0_rx_rd_valid = man_vld;
          rd_if.c0_rx_mdata    = man_md;
          rd_if.c0_rx_data     = man_dat;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        if (rd_if.out_valid && rd_if.out_ready) begin
          pop_idx_log.push_back(rd_if.out_idx);
          pop_dat_log.push_back(rd_if.out_data);
        end
        if (rd_if.done) done_cnt++;
        if (rd_if.busy) busy_cyc++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic clear_logs();
    req_addr_log.delete();
    req_md_log.delete();
    pop_idx_log.delete();
    pop_dat_log.delete();
    done_cnt = 0;
    busy_cyc = 0;
  endtask

  task automatic pulse_start(input logic [AB-1:0] a, input logic [LB-1:0] n);
    @(negedge clk);
    rd_if.start      = 1'b1;
    rd_if.start_addr = a;
    rd_if.num_lines  = n;
    @(negedge clk);
    rd_if.start      = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    for (int i = 0; i < max_cyc && done_cnt == 0; i++) @(negedge clk);
    ok = (done_cnt > 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rd_if.start = 1'b0;
    rd_if.start_addr = '0;
    rd_if.num_lines = '0;
    rd_if.c0_tx_alm_full = 1'b0;
    rd_if.out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rd_if.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", rd_if.busy); else n_pass++;
    n_checks++; if (rd_if.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", rd_if.done); else n_pass++;
    n_checks++; if (rd_if.c0_tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", rd_if.c0_tx_valid); else n_pass++;
    n_checks++; if (rd_if.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", rd_if.out_valid); else n_pass++;
    n_checks++; if (rd_if.c0_tx_addr !== '0) $display("FAIL reset_tx_addr: got %0h expected 0", rd_if.c0_tx_addr); else n_pass++;
    n_checks++; if (rd_if.c0_tx_mdata !== '0) $display("FAIL reset_tx_mdata: got %0h expected 0", rd_if.c0_tx_mdata); else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs();
    pulse_start(42'h1000, 4);
    wait_done(300, ok);
    n_checks++; if (!ok) $display("FAIL basic_done_timeout: got no done expected done"); else n_pass++;
    n_checks++; if (req_addr_log.size() != 4) $display("FAIL basic_req_count: got %0d expected 4", req_addr_log.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (get_addr(i) !== AB'(42'h1000 + i)) $display("FAIL basic_addr[%0d]: got %0h expected %0h", i, get_addr(i), 42'h1000 + i); else n_pass++;
      n_checks++; if (get_md(i) !== MB'(i)) $display("FAIL basic_mdata[%0d]: got %0h expected %0h", i, get_md(i), i); else n_pass++;
      n_checks++; if (get_idx(i) !== MB'(i)) $display("FAIL basic_idx[%0d]: got %0h expected %0h", i, get_idx(i), i); else n_pass++;
      n_checks++; if (get_dat(i) !== line_of(AB'(42'h1000 + i))) $display("FAIL basic_data[%0d]: got %0h expected %0h", i, get_dat(i), line_of(AB'(42'h1000 + i))); else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt); else n_pass++;
    n_checks++; if (rd_if.busy !== 1'b0) $display("FAIL basic_busy_after: got %b expected 0", rd_if.busy); else n_pass++;
  endtask

  task automatic test_zero_len();
    clear_logs();
    pulse_start(42'h7000, 0);
    n_checks++; if (rd_if.done !== 1'b1) $display("FAIL zero_done_pulse: got %b expected 1", rd_if.done); else n_pass++;
    n_checks++; if (rd_if.busy !== 1'b1) $display("FAIL zero_busy_high: got %b expected 1", rd_if.busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (rd_if.done !== 1'b0) $display("FAIL zero_done_clear: got %b expected 0", rd_if.done); else n_pass++;
    n_checks++; if (rd_if.busy !== 1'b0) $display("FAIL zero_busy_clear: got %b expected 0", rd_if.busy); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (busy_cyc != 1) $display("FAIL zero_busy_cycles: got %0d expected 1", busy_cyc); else n_pass++;
    n_checks++; if (req_addr_log.size() != 0) $display("FAIL zero_no_requests: got %0d expected 0", req_addr_log.size()); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL zero_done_count: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_credit_limit();
    bit ok;
    clear_logs();
    rd_if.out_ready = 1'b0;
    pulse_start(42'h8000, 16);
    repeat (40) @(negedge clk);
    n_checks++; if (req_addr_log.size() != MAXO) $display("FAIL credit_stall_count: got %0d expected %0d", req_addr_log.size(), MAXO); else n_pass++;
    n_checks++; if (rd_if.out_valid !== 1'b1) $display("FAIL credit_out_valid: got %b expected 1", rd_if.out_valid); else n_pass++;
    n_checks++; if (rd_if.out_idx !== MB'(0)) $display("FAIL credit_head_idx: got %0h expected 0", rd_if.out_idx); else n_pass++;
    @(negedge clk);
    n_checks++; if (rd_if.out_data !== line_of(AB'(42'h8000))) $display("FAIL credit_head_stable: got %0h expected %0h", rd_if.out_data, line_of(AB'(42'h8000))); else n_pass++;
    rd_if.out_ready = 1'b1;
    wait_done(600, ok);
    n_checks++; if (!ok) $display("FAIL credit_done_timeout: got no done expected done"); else n_pass++;
    n_checks++; if (req_addr_log.size() != 16) $display("FAIL credit_req_total: got %0d expected 16", req_addr_log.size()); else n_pass++;
    n_checks++; if (pop_idx_log.size() != 16) $display("FAIL credit_pop_total: got %0d expected 16", pop_idx_log.size()); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (get_idx(i) !== MB'(i)) $display("FAIL credit_idx[%0d]: got %0h expected %0h", i, get_idx(i), i); else n_pass++;
    end
    n_checks++; if (get_dat(15) !== line_of(AB'(42'h800F))) $display("FAIL credit_last_data: got %0h expected %0h", get_dat(15), line_of(AB'(42'h800F))); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL credit_done_count: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_alm_full();
    bit ok;
    int base;
    clear_logs();
    pulse_start(42'h2000, 8);
    for (int i = 0; i < 50 && req_addr_log.size() < 2; i++) @(negedge clk);
    n_checks++; if (req_addr_log.size() < 2) $display("FAIL alm_pre_timeout: got %0d requests expected >=2", req_addr_log.size()); else n_pass++;
    rd_if.c0_tx_alm_full = 1'b1;
    #1;
    base = req_addr_log.size();
    repeat (20) @(negedge clk);
    #1;
    n_checks++; if (req_addr_log.size() - base > 1) $display("FAIL alm_hold_requests: got %0d extra expected <=1", req_addr_log.size() - base); else n_pass++;
    n_checks++; if (rd_if.busy !== 1'b1) $display("FAIL alm_busy_hold: got %b expected 1", rd_if.busy); else n_pass++;
    @(negedge clk);
    rd_if.c0_tx_alm_full = 1'b0;
    wait_done(400, ok);
    n_checks++; if (!ok) $display("FAIL alm_done_timeout: got no done expected done"); else n_pass++;
    n_checks++; if (req_addr_log.size() != 8) $display("FAIL alm_req_total: got %0d expected 8", req_addr_log.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (get_addr(i) !== AB'(42'h2000 + i)) $display("FAIL alm_addr[%0d]: got %0h expected %0h", i, get_addr(i), 42'h2000 + i); else n_pass++;
    end
    n_checks++; if (pop_idx_log.size() != 8) $display("FAIL alm_pop_total: got %0d expected 8", pop_idx_log.size()); else n_pass++;
  endtask

  task automatic test_out_of_order();
    bit ok;
    int ord[4] = '{2, 0, 3, 1};
    clear_logs();
    auto_resp = 1'b0;
    pulse_start(42'h3000, 4);
    for (int i = 0; i < 50 && req_addr_log.size() < 4; i++) @(negedge clk);
    n_checks++; if (req_addr_log.size() != 4) $display("FAIL ooo_req_count: got %0d expected 4", req_addr_log.size()); else n_pass++;
    pend.delete();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      man_vld = 1'b1;
      man_md  = MB'(ord[k]);
      man_dat = line_of(AB'(42'h3000 + ord[k]));
    end
    @(posedge clk);
    man_vld = 1'b0;
    wait_done(100, ok);
    n_checks++; if (!ok) $display("FAIL ooo_done_timeout: got no done expected done"); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (get_idx(i) !== MB'(ord[i])) $display("FAIL ooo_idx[%0d]: got %0h expected %0h", i, get_idx(i), ord[i]); else n_pass++;
      n_checks++; if (get_dat(i) !== line_of(AB'(42'h3000 + ord[i]))) $display("FAIL ooo_data[%0d]: got %0h expected %0h", i, get_dat(i), line_of(AB'(42'h3000 + ord[i]))); else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL ooo_done_count: got %0d expected 1", done_cnt); else n_pass++;
    auto_resp = 1'b1;
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    clear_logs();
    pulse_start(42'h4000, 20);
    for (int i = 0; i < 200 && req_addr_log.size() < 5; i++) @(negedge clk);
    n_checks++; if (req_addr_log.size() < 5) $display("FAIL rst_pre_timeout: got %0d requests expected >=5", req_addr_log.size()); else n_pass++;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (rd_if.busy !== 1'b0) $display("FAIL rst_async_busy: got %b expected 0", rd_if.busy); else n_pass++;
    n_checks++; if (rd_if.c0_tx_valid !== 1'b0) $display("FAIL rst_async_tx_valid: got %b expected 0", rd_if.c0_tx_valid); else n_pass++;
    n_checks++; if (rd_if.out_valid !== 1'b0) $display("FAIL rst_async_out_valid: got %b expected 0", rd_if.out_valid); else n_pass++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    pulse_start(42'h5000, 3);
    wait_done(200, ok);
    n_checks++; if (!ok) $display("FAIL rst_restart_timeout: got no done expected done"); else n_pass++;
    n_checks++; if (req_addr_log.size() != 3) $display("FAIL rst_restart_reqs: got %0d expected 3", req_addr_log.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (get_addr(i) !== AB'(42'h5000 + i)) $display("FAIL rst_restart_addr[%0d]: got %0h expected %0h", i, get_addr(i), 42'h5000 + i); else n_pass++;
      n_checks++; if (get_idx(i) !== MB'(i)) $display("FAIL rst_restart_idx[%0d]: got %0h expected %0h", i, get_idx(i), i); else n_pass++;
      n_checks++; if (get_dat(i) !== line_of(AB'(42'h5000 + i))) $display("FAIL rst_restart_data[%0d]: got %0h expected %0h", i, get_dat(i), line_of(AB'(42'h5000 + i))); else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL rst_restart_done_count: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_credit_limit();
    test_alm_full();
    test_out_of_order();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
